// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM encoding and counter-sizing helper for the serial bit source
package serial_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/serial_bit_source_bit_tick_div.sv
// bit_tick_div: DIV-cycle enable counter with clear, ticks on the cycle the count reaches DIV-1
module bit_tick_div
  import serial_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int DW = clog2_min1(DIV);
  logic [DW-1:0] r_cnt;
  assign o_tick = i_en && (r_cnt == DW'(DIV - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else r_cnt <= (i_clr || o_tick) ? '0 : i_en ? r_cnt + 1'b1 : r_cnt;
endmodule

// File: rtl/serial_bit_source.sv
// serial_bit_source: MSB-first parallel-to-serial stage; SERIAL_BIT_SOURCE_PARITY_EN appends an even-parity bit
module serial_bit_source
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int BW      = $clog2(NBITS + 1);
  localparam int GAP_CYC = GAP * DIV;
  localparam int GW      = clog2_min1(GAP_CYC);
  state_t           r_state, w_state_nxt;
  logic [NBITS-1:0] r_shift, w_shift_nxt, w_load;
  logic [BW-1:0]    r_bit_cnt, w_bit_nxt;
  logic [GW-1:0]    r_gap_cnt, w_gap_nxt;
  logic             r_done, w_done_nxt, w_tick;
  // parity rides in the low end of the frame so it leaves right after the LSB
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
  assign w_load = {data_in, ^data_in};
`else
  assign w_load = data_in;
`endif
  bit_tick_div #(.DIV(DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state == ST_SHIFT),
    .i_clr  (r_state != ST_SHIFT),
    .o_tick (w_tick)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_done    <= w_done_nxt;
    end
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: if (data_valid) begin
        w_shift_nxt = w_load;
        w_bit_nxt   = '0;
        w_gap_nxt   = '0;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: if (w_tick) begin
        w_shift_nxt = {r_shift[NBITS-2:0], 1'b0};
        w_bit_nxt   = r_bit_cnt + 1'b1;
        if (r_bit_cnt == BW'(NBITS - 1)) begin
          w_done_nxt  = 1'b1;
          w_gap_nxt   = '0;
          w_state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        w_gap_nxt   = r_gap_cnt + 1'b1;
        w_state_nxt = (r_gap_cnt == GW'(GAP_CYC - 1)) ? ST_IDLE : ST_GAP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end
  assign data_ready = (r_state == ST_IDLE);
  assign ser_valid  = (r_state == ST_SHIFT);
  assign busy       = (r_state != ST_IDLE);
  assign ser_out    = ser_valid && r_shift[NBITS-1];
  assign done       = r_done;
endmodule

// File: tb/tb_serial_bit_source.sv
// tb_serial_bit_source: directed scoreboard bench for serial_bit_source
module tb_serial_bit_source;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  logic       clk = 1'b0, rst = 1'b0;
  logic [7:0] a_din = '0, b_din = '0;
  logic       a_v = 1'b0, b_v = 1'b0;
  logic       a_ser, a_sv, a_busy, a_done, a_rdy;
  logic       b_ser, b_sv, b_busy, b_done, b_rdy;
  logic       q[$];
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_bit_source #(.WIDTH(8), .DIV(4), .GAP(2)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_din), .data_valid(a_v), .data_ready(a_rdy),
    .ser_out(a_ser), .ser_valid(a_sv), .busy(a_busy), .done(a_done)
  );
  serial_bit_source #(.WIDTH(8), .DIV(1), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_din), .data_valid(b_v), .data_ready(b_rdy),
    .ser_out(b_ser), .ser_valid(b_sv), .busy(b_busy), .done(b_done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_word(input logic [7:0] w, input int div);
    for (int i = 7; i >= 0; i--) repeat (div) q.push_back(w[i]);
    if (NB == 9) repeat (div) q.push_back(^w);
  endtask
  task automatic chk_idle_a(input string tag);
    chk({tag, "_ser_out"}, a_ser, 0);
    chk({tag, "_ser_valid"}, a_sv, 0);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_done"}, a_done, 0);
    chk({tag, "_ready"}, a_rdy, 1);
  endtask
  initial begin
    logic ev, e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_a("rst_a");
    chk("rst_b_ready", b_rdy, 1);
    chk("rst_b_ser_out", b_ser, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_a("post_rst_a");
    a_din = 8'hB6;
    a_v = 1'b1;
    push_word(8'hB6, 4);
    @(posedge clk);
    for (int k = 1; k <= NB * 4 + 12; k++) begin
      @(negedge clk);
      ev = (k <= NB * 4);
      e = ev ? q.pop_front() : 1'b0;
      chk("single_ser_valid", a_sv, ev);
      chk("single_ser_out", a_ser, e);
      chk("single_done", a_done, k == NB * 4 + 1);
      chk("single_busy", a_busy, k <= NB * 4 + 8);
      chk("single_ready", a_rdy, k > NB * 4 + 8);
      if (k == 1) a_din = 8'hFF;
      if (k == 20) a_v = 1'b0;
    end
    chk("single_queue_empty", q.size(), 0);
    b_din = 8'h0F;
    b_v = 1'b1;
    push_word(8'h0F, 1);
    push_word(8'hF0, 1);
    @(posedge clk);
    for (int k = 1; k <= 2 * NB + 3; k++) begin
      @(negedge clk);
      ev = (k <= NB) || (k >= NB + 2 && k <= 2 * NB + 1);
      e = ev ? q.pop_front() : 1'b0;
      chk("b2b_ser_valid", b_sv, ev);
      chk("b2b_ser_out", b_ser, e);
      chk("b2b_done", b_done, k == NB + 1 || k == 2 * NB + 2);
      chk("b2b_ready", b_rdy, k == NB + 1 || k >= 2 * NB + 2);
      if (k == 1) b_din = 8'hF0;
      if (k == NB + 2) b_v = 1'b0;
    end
    chk("b2b_queue_empty", q.size(), 0);
    a_din = 8'hB6;
    a_v = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) a_v = 1'b0;
    end
    chk("mid_bit3_ser_out", a_ser, 1);
    chk("mid_bit3_ser_valid", a_sv, 1);
    rst = 1'b0;
    #1;
    chk_idle_a("mid_async");
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk_idle_a("mid_after");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
